// File: rtl/pll_cfg_writer.sv
// PLL reconfiguration writer: buffers (addr, data) writes, replays them over Avalon-MM, starts and awaits relock.
// Define PLL_CFG_READBACK_EN to verify each buffered write with a read of the same address.
module pll_cfg_writer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 6,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic              apply,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic [31:0]       mgmt_writedata,
  output logic              mgmt_write,
  input  logic              mgmt_waitrequest,
`ifdef PLL_CFG_READBACK_EN
  output logic              mgmt_read,
  input  logic [31:0]       mgmt_readdata,
`endif
  input  logic              pll_locked
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_MODE, S_WRITE, S_READ, S_START, S_LOCK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W+31:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sync1_q, sync2_q;
  logic                wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                done_q, done_d, error_q, error_d;
  logic                fifo_empty, fifo_full, push, wr_done, rd_done, rb_bad;
  logic [ADDR_W+31:0]  head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready   = (state_q == S_IDLE) && !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign wr_done    = wr_q && !mgmt_waitrequest;

`ifdef PLL_CFG_READBACK_EN
  assign rd_done    = rd_q && !mgmt_waitrequest;
  assign rb_bad     = (mgmt_readdata != data_q);
  assign mgmt_read  = rd_q;
`else
  assign rd_done    = 1'b0;
  assign rb_bad     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (apply && !fifo_empty) state_d = S_MODE;
      S_MODE:  if (wr_done) state_d = S_WRITE;
`ifdef PLL_CFG_READBACK_EN
      S_WRITE: if (wr_done) state_d = S_READ;
      S_READ:  if (rd_done) state_d = rb_bad ? S_IDLE : (fifo_empty ? S_START : S_WRITE);
`else
      S_WRITE: if (wr_done) state_d = fifo_empty ? S_START : S_WRITE;
`endif
      S_START: if (wr_done) state_d = S_LOCK;
      S_LOCK:  if (sync2_q || cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes drop on the completing edge and re-arm one cycle later, giving the mandatory idle gap.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_MODE, S_START: begin
        if (!wr_q) begin
          wr_d   = 1'b1;
          addr_d = (state_q == S_START) ? ADDR_W'(2) : '0;
          data_d = '0;
        end else if (!mgmt_waitrequest) begin
          wr_d  = 1'b0;
          cnt_d = '0;
        end
      end
      S_WRITE: begin
        if (!wr_q) begin
          wr_d     = 1'b1;
          addr_d   = head[ADDR_W+31:32];
          data_d   = head[31:0];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else if (!mgmt_waitrequest) begin
          wr_d = 1'b0;
        end
      end
      S_READ: begin
        if (!rd_q) begin
          rd_d = 1'b1;
        end else if (rd_done) begin
          rd_d = 1'b0;
          if (rb_bad) begin
            error_d  = 1'b1;
            rd_ptr_d = wr_ptr_q;
          end
        end
      end
      S_LOCK: begin
        if (sync2_q)                done_d  = 1'b1;
        else if (cnt_q == CNT_LAST) error_d = 1'b1;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sync1_q  <= pll_locked;
      sync2_q  <= sync1_q;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_addr, in_data};
  end

  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Self-checking bench for pll_cfg_writer: queue-based transfer model, randomized entries and waitrequest.
module tb_pll_cfg_writer;
  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int TMO   = 100;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, apply = 1'b0, mgmt_waitrequest = 1'b0, pll_locked = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [31:0]   in_data = '0;
  logic          in_ready, busy, done, error, mgmt_write;
  logic [AW-1:0] mgmt_address;
  logic [31:0]   mgmt_writedata;
`ifdef PLL_CFG_READBACK_EN
  logic          mgmt_read;
  logic [31:0]   mgmt_readdata;
  logic [31:0]   shadow [64];
  bit            corrupt = 0;
  always @* mgmt_readdata = shadow[mgmt_address] ^ ((corrupt && mgmt_address == 3) ? 32'h1 : 32'h0);
`endif

  pll_cfg_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .apply(apply), .busy(busy),
    .done(done), .error(error), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
`ifdef PLL_CFG_READBACK_EN
    .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata),
`endif
    .pll_locked(pll_locked));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [AW-1:0] rec_a[$], exp_a[$], pend_a[$];
  logic [31:0]   rec_d[$], exp_d[$], pend_d[$];
  int            rec_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Completed transfers are seen one half-cycle before the completing edge.
  always @(negedge clk) begin
    if (rst_n && mgmt_write && !mgmt_waitrequest) begin
      rec_a.push_back(mgmt_address);
      rec_d.push_back(mgmt_writedata);
      rec_cyc.push_back(cyc + 1);
`ifdef PLL_CFG_READBACK_EN
      shadow[mgmt_address] = mgmt_writedata;
`endif
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rand_pend(input int n);
    pend_a.delete(); pend_d.delete();
    for (int i = 0; i < n; i++) begin
      pend_a.push_back(AW'($urandom_range(0, 63)));
      pend_d.push_back($urandom);
    end
  endtask

  // Expected replay: mode write, buffered entries in push order, start write.
  task automatic load_and_apply();
    exp_a.delete(); exp_d.delete(); rec_a.delete(); rec_d.delete(); rec_cyc.delete();
    exp_a.push_back('0); exp_d.push_back('0);
    for (int i = 0; i < pend_a.size(); i++) begin
      push(pend_a[i], pend_d[i]);
      exp_a.push_back(pend_a[i]); exp_d.push_back(pend_d[i]);
    end
    exp_a.push_back(AW'(2)); exp_d.push_back('0);
    apply = 1'b1; tick(); apply = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget, input bit rnd, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (rec_a.size() >= n) begin ok = 1; break; end
      if (rnd) mgmt_waitrequest = ($urandom_range(0, 2) == 0);
      tick();
    end
    mgmt_waitrequest = 1'b0;
  endtask

  task automatic lock_pll(output int lat);
    pll_locked = 1'b1; lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); lat++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; repeat (3) tick(); rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    tick();
    n_checks++; if ({busy, done, error, mgmt_write} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, mgmt_write}); else n_pass++;
    n_checks++; if (mgmt_address !== '0 || mgmt_writedata !== '0) $display("FAIL reset_bus got=%0d/%h exp=0/0", mgmt_address, mgmt_writedata); else n_pass++;
`ifdef PLL_CFG_READBACK_EN
    n_checks++; if (mgmt_read !== 1'b0) $display("FAIL reset_read got=%b exp=0", mgmt_read); else n_pass++;
`endif
  endtask

  task automatic test_apply_empty();
    bit seen = 0;
    rec_a.delete(); rec_d.delete();
    apply = 1'b1; tick(); apply = 1'b0;
    repeat (6) begin if (busy || mgmt_write) seen = 1; tick(); end
    n_checks++; if (seen || rec_a.size() != 0) $display("FAIL apply_empty got=busy_or_write exp=idle"); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int lat;
    pend_a = '{AW'(4), AW'(3), AW'(5)};
    pend_d = '{32'h00010101, 32'h00000202, 32'h00000505};
    load_and_apply();
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else n_pass++;
    wait_xfers(5, 400, 0, ok);
    n_checks++; if (!ok || rec_a.size() != 5) $display("FAIL basic_count got=%0d exp=5", rec_a.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= rec_a.size() || rec_a[i] !== exp_a[i] || rec_d[i] !== exp_d[i])
        $display("FAIL basic_xfer%0d got=%0d/%h exp=%0d/%h", i, rec_a[i], rec_d[i], exp_a[i], exp_d[i]);
      else n_pass++;
    end
    lock_pll(lat);
    n_checks++; if (done !== 1'b1 || lat < 3 || lat > 4) $display("FAIL basic_done got=%b lat=%0d exp=1 lat=3..4", done, lat); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got=%b exp=0", busy); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else n_pass++;
    pll_locked = 1'b0; repeat (4) tick();
  endtask

  task automatic test_waitreq();
    bit ok, stable; int lat;
    logic [AW-1:0] a0; logic [31:0] d0;
    rand_pend(2);
    mgmt_waitrequest = 1'b1;
    load_and_apply();
    ok = 0; for (int i = 0; i < 50; i++) begin if (mgmt_write === 1'b1) begin ok = 1; break; end tick(); end
    mgmt_waitrequest = 1'b0; tick(); mgmt_waitrequest = 1'b1;
    ok = 0; for (int i = 0; i < 50; i++) begin if (mgmt_write === 1'b1) begin ok = 1; break; end tick(); end
    a0 = mgmt_address; d0 = mgmt_writedata; stable = ok;
    repeat (7) begin
      tick();
      if (!(mgmt_write === 1'b1 && mgmt_address === a0 && mgmt_writedata === d0)) stable = 0;
    end
    n_checks++; if (!stable || a0 !== exp_a[1] || d0 !== exp_d[1]) $display("FAIL wait_stable got=%0d/%h exp=%0d/%h", a0, d0, exp_a[1], exp_d[1]); else n_pass++;
    n_checks++; if (rec_a.size() != 1) $display("FAIL wait_no_early got=%0d exp=1", rec_a.size()); else n_pass++;
    mgmt_waitrequest = 1'b0;
    wait_xfers(4, 400, 0, ok);
    repeat (5) tick();
    n_checks++; if (rec_a.size() != 4) $display("FAIL wait_count got=%0d exp=4", rec_a.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rec_a[i] !== exp_a[i] || rec_d[i] !== exp_d[i]) $display("FAIL wait_xfer%0d got=%0d/%h exp=%0d/%h", i, rec_a[i], rec_d[i], exp_a[i], exp_d[i]);
      else n_pass++;
    end
    lock_pll(lat); tick(); pll_locked = 1'b0; repeat (4) tick();
  endtask

  task automatic test_full();
    bit ok; int acc = 0, lat;
    pend_a.delete(); pend_d.delete();
    exp_a.delete(); exp_d.delete(); rec_a.delete(); rec_d.delete();
    exp_a.push_back('0); exp_d.push_back('0);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_addr = AW'($urandom_range(0, 63)); in_data = $urandom;
      if (in_ready) begin acc++; exp_a.push_back(in_addr); exp_d.push_back(in_data); end
      tick();
    end
    n_checks++; if (acc != DEPTH) $display("FAIL full_accept got=%0d exp=%0d", acc, DEPTH); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", in_ready); else n_pass++;
    in_addr = AW'(63); in_data = 32'hDEADBEEF; repeat (2) tick(); in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready_hold got=%b exp=0", in_ready); else n_pass++;
    exp_a.push_back(AW'(2)); exp_d.push_back('0);
    apply = 1'b1; tick(); apply = 1'b0;
    wait_xfers(DEPTH + 2, 800, 1, ok);
    repeat (5) tick();
    n_checks++; if (rec_a.size() != DEPTH + 2) $display("FAIL full_count got=%0d exp=%0d", rec_a.size(), DEPTH + 2); else n_pass++;
    for (int i = 0; i < DEPTH + 2; i++) begin
      n_checks++;
      if (rec_a[i] !== exp_a[i] || rec_d[i] !== exp_d[i]) $display("FAIL full_xfer%0d got=%0d/%h exp=%0d/%h", i, rec_a[i], rec_d[i], exp_a[i], exp_d[i]);
      else n_pass++;
    end
    lock_pll(lat); tick(); pll_locked = 1'b0; repeat (4) tick();
  endtask

  task automatic test_random();
    bit ok, good; int lat, n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, DEPTH);
      rand_pend(n);
      load_and_apply();
      wait_xfers(n + 2, 1000, 1, ok);
      repeat (5) tick();
      good = ok && (rec_a.size() == n + 2);
      for (int i = 0; i < n + 2 && good; i++)
        if (rec_a[i] !== exp_a[i] || rec_d[i] !== exp_d[i]) good = 0;
      n_checks++; if (!good) $display("FAIL random%0d_xfers got=%0d exp=%0d", it, rec_a.size(), n + 2); else n_pass++;
      lock_pll(lat);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL random%0d_done got=%b/%b exp=1/0", it, done, busy); else n_pass++;
      tick(); pll_locked = 1'b0; repeat (4) tick();
    end
  endtask

  task automatic test_timeout();
    bit ok; int d0, t_start, t_err = -1;
    rand_pend(1);
    d0 = done_cnt;
    load_and_apply();
    wait_xfers(3, 300, 0, ok);
    t_start = ok ? rec_cyc[2] : 0;
    for (int i = 0; i < TMO + 50; i++) begin
      if (error === 1'b1) begin t_err = cyc; break; end
      tick();
    end
    n_checks++; if (t_err - t_start != TMO) $display("FAIL timeout_cycles got=%0d exp=%0d", t_err - t_start, TMO); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", busy); else n_pass++;
    tick();
    n_checks++; if (error !== 1'b0 || done_cnt != d0) $display("FAIL timeout_pulse got=%b/%0d exp=0/%0d", error, done_cnt, d0); else n_pass++;
    apply = 1'b1; tick(); apply = 1'b0; tick();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL timeout_empty got=%b/%b exp=0/1", busy, in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int d0, e0;
    rand_pend(3);
    load_and_apply();
    wait_xfers(1, 100, 0, ok);
    mgmt_waitrequest = 1'b1;
    ok = 0; for (int i = 0; i < 50; i++) begin if (mgmt_write === 1'b1) begin ok = 1; break; end tick(); end
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0; tick();
    n_checks++; if (!ok || mgmt_write !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_drop got=%b/%b exp=0/0", mgmt_write, busy); else n_pass++;
    rst_n = 1'b1; mgmt_waitrequest = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", in_ready); else n_pass++;
    tick();
    apply = 1'b1; tick(); apply = 1'b0;
    repeat (20) tick();
    n_checks++; if (rec_a.size() != 1 || busy !== 1'b0) $display("FAIL rstmid_flush got=%0d/%b exp=1/0", rec_a.size(), busy); else n_pass++;
    n_checks++; if (done_cnt != d0 || err_cnt != e0) $display("FAIL rstmid_pulse got=%0d/%0d exp=%0d/%0d", done_cnt, err_cnt, d0, e0); else n_pass++;
  endtask

`ifdef PLL_CFG_READBACK_EN
  task automatic test_readback();
    bit seen = 0, start_seen = 0;
    pend_a = '{AW'(4), AW'(3), AW'(5)};
    pend_d = '{32'h00010101, 32'h00000202, 32'h00000505};
    corrupt = 1;
    load_and_apply();
    for (int i = 0; i < 300; i++) begin
      if (error === 1'b1) begin seen = 1; break; end
      tick();
    end
    n_checks++; if (!seen) $display("FAIL rb_error got=0 exp=1"); else n_pass++;
    tick();
    foreach (rec_a[i]) if (rec_a[i] == 2) start_seen = 1;
    n_checks++; if (start_seen || rec_a.size() != 3) $display("FAIL rb_no_start got=%0d writes exp=3", rec_a.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0 || error !== 1'b0) $display("FAIL rb_idle got=%b/%b exp=0/0", busy, error); else n_pass++;
    corrupt = 0;
    apply = 1'b1; tick(); apply = 1'b0; tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL rb_flush got=%b exp=0", busy); else n_pass++;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog cycles=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_apply_empty();
    test_basic();
    test_waitreq();
    test_full();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef PLL_CFG_READBACK_EN
    test_readback();
`endif
    n_checks++; if (both_cnt != 0) $display("FAIL done_error_overlap got=%0d exp=0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
